tmds_rx_decode: RTL and testbench
=================================

# tmds_rx_decode

Receive-side TMDS decoder for the HDMI output path. It accepts three word-aligned 10-bit TMDS symbol streams (blue, green, red) at pixel rate. It recovers 8-bit RGB, hsync, vsync, de and pixel coordinates, and reports link lock and error statistics. It sits on the loopback and verification side of hdmi_ctrl: it decodes exactly what the transmitter encodes and regenerates the pix_x/pix_y view that vga_ctrl produces.

## Interface
Parameters:
- H_ACTIVE, 640: expected active pixels per line.
- V_ACTIVE, 480: expected active lines per frame.
- LOCK_LINES, 4: consecutive good lines required to lock.
- ERR_MAX, 15: per-frame symbol errors tolerated while locked.

Ports:
- vga_clk  in  1  pixel clock; the only clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- tmds_b  in  10  blue-channel symbol, q[9:0].
- tmds_g  in  10  green-channel symbol.
- tmds_r  in  10  red-channel symbol.
- rgb_blue  out  8  decoded blue data.
- rgb_green  out  8  decoded green data.
- rgb_red  out  8  decoded red data.
- hsync  out  1  blue-channel C0.
- vsync  out  1  blue-channel C1.
- de  out  1  data-enable; 1 when all channels carry data symbols.
- pix_x  out  10  pixel index within the current active line.
- pix_y  out  10  line index since the last vsync rising edge.
- locked  out  1  line structure matches H_ACTIVE/V_ACTIVE.
- err_cnt  out  16  saturating total error count.

## Operation
- Control tokens, per channel:
  - 1101010100 decodes to C1C0=00.
  - 0010101011 decodes to 01.
  - 0101010100 decodes to 10.
  - 1010101011 decodes to 11.
  - Any other symbol is a data symbol.
- Data decode:
  - d = q[9] ? ~q[7:0] : q[7:0].
  - out[0] = d[0].
  - For i = 1..7: out[i] = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
- Cycle types:
  - All three channels data: de=1, RGB = decoded values, hsync/vsync hold their last values.
  - All three channels control: de=0, RGB=0, hsync/vsync = blue C0/C1. Green and red C values are ignored.
  - Mixed types (one or two channels control): symbol error. Output de=0, RGB=0, sync held; err_cnt increments.
- Coordinates:
  - pix_x: 0 on the first de=1 cycle of a line, +1 per de cycle, saturates at 1023. Holds its value while de=0.
  - pix_y: cleared on decoded vsync rising edge. +1 on each de falling edge. Saturates at 1023.
  - Line length = pix_x+1 at the de falling edge.
- Lock FSM, three states:
  - SEARCH: locked=0. A vsync rising edge moves to ALIGN with good=0.
  - ALIGN: locked=0.
    - Each de fall with line length == H_ACTIVE: good+1. Otherwise: good=0 and err_cnt+1.
    - good reaching LOCK_LINES moves to LOCKED.
    - A symbol error moves to SEARCH.
  - LOCKED: locked=1. Each of the following moves to SEARCH:
    - Line length != H_ACTIVE, with err_cnt+1.
    - A de rise while pix_y == V_ACTIVE, with err_cnt+1.
    - Per-frame symbol errors exceeding ERR_MAX.
- The per-frame symbol error counter clears on every vsync rising edge.
- err_cnt saturates at 16'hFFFF and clears only on reset.
- Reset values: all outputs 0, FSM = SEARCH, internal counters 0.

## Timing
- Latency:
  - Stage 1 registers the inputs. Stage 2 registers the decode and classification.
  - A symbol presented at edge n appears on rgb/de/hsync/vsync/pix_x at edge n+2.
- Event detection:
  - Edges (de fall, vsync rise) are detected on stage-2 values.
  - FSM, pix_y and err_cnt update on the next edge. locked therefore changes 1 cycle after the triggering event appears on the outputs.
- Simultaneous events:
  - de fall and vsync rise in the same cycle: the line is evaluated first, then pix_y clears to 0.
  - Symbol error and de fall in the same cycle: both increment err_cnt (+2).
- Reset: asynchronous assertion clears everything immediately, including mid-line. After deassertion the first valid output is at edge 2.

## Test plan
- Decode values: blue=0100000000, green=1000000000, red=0100000000 -> after 2 cycles rgb_blue=0x00, rgb_green=0xFF, rgb_red=0x00, de=1. Encoded 0x00–0xFF sweep from a reference encoder round-trips bit-exact.
- Control tokens: blue=1010101011, green=red=1101010100 -> hsync=1, vsync=1, de=0, RGB=0 after 2 cycles.
- Lock: vsync rise, then 4 lines of 640 de cycles -> locked=1 one cycle after the 4th de fall. pix_x reaches 639, pix_y=4.
- Bad line: while locked, one line of 639 pixels -> locked=0 next cycle, err_cnt+1, FSM=SEARCH. Relock requires the next vsync plus 4 good lines.
- Symbol errors: 16 mixed-type cycles in one locked frame -> locked drops after the 16th. Exactly 15 -> locked stays 1, err_cnt=15.
- Reset mid-line: assert sys_rst_n=0 at pix_x=300 -> all outputs 0 immediately. err_cnt=0, locked=0.

Source files
------------

// File: rtl/tmds_rx_decode.sv
// tmds_rx_decode: TMDS receive decoder recovering RGB/sync/de, pixel coordinates,
// and a line-structure lock with saturating error statistics.
module tmds_rx_decode #(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int LOCK_LINES = 4,
   parameter int ERR_MAX    = 15
) (
   input  logic        vga_clk,
   input  logic        sys_rst_n,
   input  logic [9:0]  tmds_b,
   input  logic [9:0]  tmds_g,
   input  logic [9:0]  tmds_r,
   output logic [7:0]  rgb_blue,
   output logic [7:0]  rgb_green,
   output logic [7:0]  rgb_red,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic        locked,
   output logic [15:0] err_cnt
);
   typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

   function automatic logic is_ctrl(input logic [9:0] q);
      return q == 10'b1101010100 || q == 10'b0010101011 ||
             q == 10'b0101010100 || q == 10'b1010101011;
   endfunction

   function automatic logic [1:0] ctrl_bits(input logic [9:0] q);
      return q == 10'b0010101011 ? 2'b01 :
             q == 10'b0101010100 ? 2'b10 :
             q == 10'b1010101011 ? 2'b11 : 2'b00;
   endfunction

   function automatic logic [7:0] decode(input logic [9:0] q);
      logic [7:0] d, o;
      d = q[9] ? ~q[7:0] : q[7:0];
      o[0] = d[0];
      for (int i = 1; i < 8; i++) o[i] = q[8] ? d[i] ^ d[i-1] : ~(d[i] ^ d[i-1]);
      return o;
   endfunction

   state_t      state, state_nx;
   logic [9:0]  s1_b, s1_g, s1_r;
   logic        s1_vld;
   logic        all_data, all_ctrl, sym_nx;
   logic [1:0]  cb;
   logic        sym_err, de_d, vs_d;
   logic        de_fall, de_rise, vs_rise, line_ok, line_err;
   logic [15:0] good, good_nx, frame_err, frame_inc, frame_nx;
   logic [16:0] err_sum;

   // s1_vld keeps the all-zero reset contents of stage 1 from decoding as data
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         s1_b   <= '0;
         s1_g   <= '0;
         s1_r   <= '0;
         s1_vld <= 1'b0;
      end else begin
         s1_b   <= tmds_b;
         s1_g   <= tmds_g;
         s1_r   <= tmds_r;
         s1_vld <= 1'b1;
      end
   end

   assign cb       = ctrl_bits(s1_b);
   assign all_data = s1_vld && !is_ctrl(s1_b) && !is_ctrl(s1_g) && !is_ctrl(s1_r);
   assign all_ctrl = s1_vld && is_ctrl(s1_b) && is_ctrl(s1_g) && is_ctrl(s1_r);
   assign sym_nx   = s1_vld && !all_data && !all_ctrl;

   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rgb_blue  <= '0;
         rgb_green <= '0;
         rgb_red   <= '0;
         hsync     <= 1'b0;
         vsync     <= 1'b0;
         de        <= 1'b0;
         pix_x     <= '0;
         sym_err   <= 1'b0;
         de_d      <= 1'b0;
         vs_d      <= 1'b0;
      end else begin
         rgb_blue  <= all_data ? decode(s1_b) : 8'd0;
         rgb_green <= all_data ? decode(s1_g) : 8'd0;
         rgb_red   <= all_data ? decode(s1_r) : 8'd0;
         hsync     <= all_ctrl ? cb[0] : hsync;
         vsync     <= all_ctrl ? cb[1] : vsync;
         de        <= all_data;
         pix_x     <= !all_data ? pix_x : !de ? 10'd0 : &pix_x ? pix_x : pix_x + 10'd1;
         sym_err   <= sym_nx;
         de_d      <= de;
         vs_d      <= vsync;
      end
   end

   assign de_fall   = de_d && !de;
   assign de_rise   = de && !de_d;
   assign vs_rise   = vsync && !vs_d;
   assign line_ok   = int'(pix_x) + 1 == H_ACTIVE;
   assign frame_inc = frame_err + 16'(sym_err && !(&frame_err));
   assign frame_nx  = vs_rise ? 16'd0 : frame_inc;

   always_comb begin
      state_nx = state;
      good_nx  = good;
      line_err = 1'b0;
      case (state)
         SEARCH: begin
            if (vs_rise) begin
               state_nx = ALIGN;
               good_nx  = '0;
            end
         end
         ALIGN: begin
            if (de_fall) begin
               good_nx  = line_ok ? good + 16'd1 : 16'd0;
               line_err = !line_ok;
               if (line_ok && int'(good) + 1 >= LOCK_LINES) state_nx = LOCKED;
            end
            if (sym_err) state_nx = SEARCH;
         end
         LOCKED: begin
            line_err = (de_fall && !line_ok) || (de_rise && int'(pix_y) == V_ACTIVE);
            if (line_err || int'(frame_inc) > ERR_MAX) state_nx = SEARCH;
         end
         default: state_nx = SEARCH;
      endcase
   end

   // a symbol error and a bad line end in the same cycle each count
   assign err_sum = {1'b0, err_cnt} + 17'(sym_err) + 17'(line_err);

   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= SEARCH;
         good      <= '0;
         frame_err <= '0;
         err_cnt   <= '0;
         pix_y     <= '0;
      end else begin
         state     <= state_nx;
         good      <= good_nx;
         frame_err <= frame_nx;
         err_cnt   <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
         pix_y     <= vs_rise ? 10'd0 : (de_fall && !(&pix_y)) ? pix_y + 10'd1 : pix_y;
      end
   end

   assign locked = state == LOCKED;
endmodule

// File: tb/tb_tmds_rx_decode.sv
// tb_tmds_rx_decode: table vectors, encoder round-trip stream and lock/error sequences.
module tb_tmds_rx_decode;
   localparam int H = 640, V = 8, LL = 4, EM = 15;
   localparam logic [9:0] T00 = 10'b1101010100, T01 = 10'b0010101011;
   localparam logic [9:0] T10 = 10'b0101010100, T11 = 10'b1010101011;
   localparam logic [9:0] D0 = 10'b0100000000, D1 = 10'b1000000000;

   logic        vga_clk = 1'b0, sys_rst_n = 1'b1;
   logic [9:0]  tmds_b = T00, tmds_g = T00, tmds_r = T00;
   logic [7:0]  rgb_blue, rgb_green, rgb_red;
   logic        hsync, vsync, de, locked;
   logic [9:0]  pix_x, pix_y;
   logic [15:0] err_cnt;
   int n_cmp = 0, n_bad = 0;
   int db = 0, dg = 0, dr = 0;

   typedef struct {
      string      nm;
      logic [9:0] b, g, r;
      logic [7:0] eb, eg, er;
      logic       ede, ehs, evs;
   } vec_t;
   vec_t tbl[9];

   always #5 vga_clk = ~vga_clk;

   tmds_rx_decode #(.H_ACTIVE(H), .V_ACTIVE(V), .LOCK_LINES(LL), .ERR_MAX(EM)) dut (
      .vga_clk(vga_clk), .sys_rst_n(sys_rst_n),
      .tmds_b(tmds_b), .tmds_g(tmds_g), .tmds_r(tmds_r),
      .rgb_blue(rgb_blue), .rgb_green(rgb_green), .rgb_red(rgb_red),
      .hsync(hsync), .vsync(vsync), .de(de),
      .pix_x(pix_x), .pix_y(pix_y), .locked(locked), .err_cnt(err_cnt)
   );

   // DVI transmitter encoder with running disparity
   function automatic logic [9:0] enc(input logic [7:0] d, input int cin, output int cout);
      logic [8:0] qm;
      logic       use_xnor;
      int         n1q, n0q;
      use_xnor = $countones(d) > 4 || ($countones(d) == 4 && !d[0]);
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : qm[i-1] ^ d[i];
      qm[8] = !use_xnor;
      n1q = $countones(qm[7:0]);
      n0q = 8 - n1q;
      if (cin == 0 || n1q == n0q) begin
         cout = qm[8] ? cin + n1q - n0q : cin + n0q - n1q;
         return {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      end else if ((cin > 0 && n1q > n0q) || (cin < 0 && n0q > n1q)) begin
         cout = cin + (qm[8] ? 2 : 0) + n0q - n1q;
         return {1'b1, qm[8], ~qm[7:0]};
      end
      cout = cin - (qm[8] ? 0 : 2) + n1q - n0q;
      return {1'b0, qm[8], qm[7:0]};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic step(input logic [9:0] b, input logic [9:0] g, input logic [9:0] r);
      tmds_b = b;
      tmds_g = g;
      tmds_r = r;
      @(posedge vga_clk);
      #1;
   endtask

   task automatic blank(input int n, input logic [9:0] btok);
      for (int i = 0; i < n; i++) step(btok, T00, T00);
   endtask

   task automatic pix(input logic [7:0] b, input logic [7:0] g, input logic [7:0] r);
      logic [9:0] sb, sg, sr;
      int c;
      sb = enc(b, db, c); db = c;
      sg = enc(g, dg, c); dg = c;
      sr = enc(r, dr, c); dr = c;
      step(sb, sg, sr);
   endtask

   task automatic line(input int n);
      for (int i = 0; i < n; i++) pix(8'($urandom), 8'($urandom), 8'($urandom));
   endtask

   task automatic vsync_pulse();
      blank(3, T00);
      blank(3, T10);
      blank(3, T00);
   endtask

   task automatic lock_up();
      vsync_pulse();
      for (int l = 0; l < LL; l++) begin
         line(H);
         blank(20, T01);
      end
   endtask

   task automatic do_reset();
      #2 sys_rst_n = 1'b0;
      tmds_b = T00; tmds_g = T00; tmds_r = T00;
      @(posedge vga_clk);
      #1 sys_rst_n = 1'b1;
      db = 0; dg = 0; dr = 0;
   endtask

   initial begin
      logic [23:0] exp_rgb, prev_rgb;
      logic [7:0]  vb, vg, vr;
      tbl[0] = '{"dec_00ff00", D0, D1, D0, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{"ctrl_11", T11, T00, T00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
      tbl[2] = '{"data_holds_sync", D0, D1, D0, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b1};
      tbl[3] = '{"ctrl_01", T01, T00, T00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{"ctrl_gr_ignored", T10, T11, T01, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
      tbl[5] = '{"mixed_g_data", T01, D0, T00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
      tbl[6] = '{"mixed_b_data", D0, T11, T00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
      tbl[7] = '{"ctrl_00", T00, T00, T00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[8] = '{"dec_01fffe", 10'b1100000000, 10'b0011111111, 10'b0110101010,
                 8'h01, 8'hFF, 8'hFE, 1'b1, 1'b0, 1'b0};

      // reset: async assertion, then first valid output on the second edge
      tmds_b = D0; tmds_g = D1; tmds_r = D0;
      #2 sys_rst_n = 1'b0;
      #1;
      chk("rst_de", 32'(de), 0);
      chk("rst_rgb", 32'({rgb_blue, rgb_green, rgb_red}), 0);
      chk("rst_locked", 32'(locked), 0);
      chk("rst_err", 32'(err_cnt), 0);
      chk("rst_pix", 32'({pix_x, pix_y}), 0);
      repeat (2) @(posedge vga_clk);
      #1 sys_rst_n = 1'b1;
      @(posedge vga_clk); #1;
      chk("edge1_de", 32'(de), 0);
      chk("edge1_rgb", 32'({rgb_blue, rgb_green, rgb_red}), 0);
      @(posedge vga_clk); #1;
      chk("edge2_de", 32'(de), 1);
      chk("edge2_rgb", 32'({rgb_blue, rgb_green, rgb_red}), 32'h00FF00);

      foreach (tbl[i]) begin
         step(tbl[i].b, tbl[i].g, tbl[i].r);
         step(tbl[i].b, tbl[i].g, tbl[i].r);
         chk({tbl[i].nm, "_rgb"}, 32'({rgb_blue, rgb_green, rgb_red}),
             32'({tbl[i].eb, tbl[i].eg, tbl[i].er}));
         chk({tbl[i].nm, "_de"}, 32'(de), 32'(tbl[i].ede));
         chk({tbl[i].nm, "_sync"}, 32'({hsync, vsync}), 32'({tbl[i].ehs, tbl[i].evs}));
      end

      // encoder round trip: 0..255 sweep then random pixels; pix_x saturates at 1023
      blank(2, T00);
      prev_rgb = '0;
      for (int i = 0; i < 1100; i++) begin
         vb = i < 256 ? 8'(i) : 8'($urandom);
         vg = i < 256 ? 8'(255 - i) : 8'($urandom);
         vr = 8'($urandom);
         pix(vb, vg, vr);
         if (i > 0) begin
            chk("stream_rgb", 32'({rgb_blue, rgb_green, rgb_red}), 32'(prev_rgb));
            chk("stream_de", 32'(de), 1);
            chk("stream_pix_x", 32'(pix_x), (i - 1) > 1023 ? 1023 : i - 1);
         end
         prev_rgb = {vb, vg, vr};
      end
      blank(1, T00);
      chk("stream_last_rgb", 32'({rgb_blue, rgb_green, rgb_red}), 32'(prev_rgb));
      chk("stream_sat_x", 32'(pix_x), 1023);
      blank(3, T00);

      // lock after vsync plus LL good lines
      do_reset();
      vsync_pulse();
      for (int l = 0; l < LL - 1; l++) begin
         line(H);
         blank(20, T01);
      end
      line(H);
      blank(2, T00);
      chk("lock_pre_de", 32'(de), 0);
      chk("lock_pre_x", 32'(pix_x), H - 1);
      chk("lock_pre_locked", 32'(locked), 0);
      blank(1, T00);
      chk("lock_locked", 32'(locked), 1);
      chk("lock_pix_y", 32'(pix_y), LL);
      chk("lock_err", 32'(err_cnt), 0);
      blank(17, T01);

      // short line while locked
      line(H - 1);
      blank(2, T01);
      chk("bad_still_locked", 32'(locked), 1);
      blank(1, T01);
      chk("bad_unlocked", 32'(locked), 0);
      chk("bad_err", 32'(err_cnt), 1);
      blank(17, T01);

      // relock; last line's de fall coincides with a vsync rise
      vsync_pulse();
      for (int l = 0; l < LL - 1; l++) begin
         line(H);
         blank(20, T01);
      end
      line(H);
      blank(2, T10);
      chk("relock_pending", 32'(locked), 0);
      blank(1, T10);
      chk("relock_locked", 32'(locked), 1);
      chk("relock_pix_y", 32'(pix_y), 0);
      chk("relock_err", 32'(err_cnt), 1);
      blank(10, T00);

      // frame overrun: a line starting at pix_y == V breaks lock
      for (int l = 0; l < V; l++) begin
         line(H);
         blank(20, T01);
      end
      chk("vmax_locked", 32'(locked), 1);
      chk("vmax_pix_y", 32'(pix_y), V);
      line(3);
      chk("vmax_unlocked", 32'(locked), 0);
      chk("vmax_err", 32'(err_cnt), 2);
      line(H - 3);
      blank(20, T01);
      chk("vmax_search_err", 32'(err_cnt), 2);

      // per-frame symbol error budget
      do_reset();
      lock_up();
      chk("sym_locked", 32'(locked), 1);
      for (int k = 0; k < EM; k++) step(T00, D0, T00);
      blank(2, T00);
      chk("sym15_locked", 32'(locked), 1);
      chk("sym15_err", 32'(err_cnt), EM);
      vsync_pulse();
      for (int k = 0; k < EM + 1; k++) step(T00, D0, T00);
      blank(1, T00);
      chk("sym16_pre_locked", 32'(locked), 1);
      chk("sym16_pre_err", 32'(err_cnt), 2 * EM);
      blank(1, T00);
      chk("sym16_unlocked", 32'(locked), 0);
      chk("sym16_err", 32'(err_cnt), 2 * EM + 1);

      // symbol error on the de fall of a short line in ALIGN: +2
      do_reset();
      vsync_pulse();
      line(10);
      step(T00, D0, T00);
      blank(3, T00);
      chk("dual_err", 32'(err_cnt), 2);
      chk("dual_locked", 32'(locked), 0);

      // asynchronous reset mid-line
      lock_up();
      line(302);
      chk("mid_pix_x", 32'(pix_x), 300);
      chk("mid_locked", 32'(locked), 1);
      #2 sys_rst_n = 1'b0;
      #1;
      chk("mid_rst_rgb", 32'({rgb_blue, rgb_green, rgb_red}), 0);
      chk("mid_rst_ctl", 32'({de, hsync, vsync, locked}), 0);
      chk("mid_rst_pix", 32'({pix_x, pix_y}), 0);
      chk("mid_rst_err", 32'(err_cnt), 0);
      @(posedge vga_clk);
      #1 sys_rst_n = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
